// File: rtl/banked_register_file.sv
// Banked register file with single and pair write/read ports, a bank-select register
// and a sequential clear engine that zeroes one bank, one register per cycle.
module banked_register_file #(
    parameter int DATA_W    = 4,
    parameter int NUM_REGS  = 16,
    parameter int NUM_BANKS = 2,
    parameter int BYPASS    = 1,
    localparam int AW = $clog2(NUM_REGS),
    localparam int PW = (AW > 1) ? AW - 1 : 1,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                pair_we,
    input  logic [PW-1:0]       pair_idx,
    input  logic [2*DATA_W-1:0] pair_din,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_W-1:0]   rdata,
    input  logic [PW-1:0]       rpair_idx,
    output logic [2*DATA_W-1:0] rpair_dout,
    input  logic                bank_we,
    input  logic [BW-1:0]       bank_in,
    output logic [BW-1:0]       bank,
    input  logic                clr_req,
    output logic                busy,
    output logic                wr_drop
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [BW-1:0]       clr_bank;
    logic [BW-1:0]       bank_next;
    logic [DATA_W-1:0]   mem [NUM_BANKS][NUM_REGS];
    logic [NUM_REGS-1:0] hit;
    logic [DATA_W-1:0]   hval [NUM_REGS];
    logic                wr_ok;
    logic [AW-1:0]       rp_ev;
    logic [AW-1:0]       rp_od;
    logic [DATA_W-1:0]   rd_ev;
    logic [DATA_W-1:0]   rd_od;

    // Bank count is a power of two, so truncation to BW bits is the modulo wrap.
    assign bank_next = (NUM_BANKS == 1) ? '0 : bank_in;
    assign wr_ok     = (state == IDLE);

    // Per-register write hit and data; the pair port overrides the single port.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i]  = 1'b0;
            hval[i] = wdata;
            if (we && waddr == AW'(i))
                hit[i] = 1'b1;
            if (pair_we && pair_idx == PW'(i / 2)) begin
                hit[i]  = 1'b1;
                hval[i] = (i % 2 == 0) ? pair_din[2*DATA_W-1:DATA_W] : pair_din[DATA_W-1:0];
            end
            hit[i] = hit[i] & wr_ok;
        end
    end

    assign rp_ev = AW'({rpair_idx, 1'b0});
    assign rp_od = rp_ev | AW'(1);

    always_comb begin
        rdata = mem[bank][raddr];
        rd_ev = mem[bank][rp_ev];
        rd_od = mem[bank][rp_od];
        if (BYPASS != 0) begin
            if (hit[raddr]) rdata = hval[raddr];
            if (hit[rp_ev]) rd_ev = hval[rp_ev];
            if (hit[rp_od]) rd_od = hval[rp_od];
        end
        rpair_dout = {rd_ev, rd_od};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int r = 0; r < NUM_REGS; r++)
                    mem[b][r] <= '0;
            bank     <= '0;
            state    <= IDLE;
            cnt      <= '0;
            clr_bank <= '0;
            busy     <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop <= 1'b0;
            if (bank_we)
                bank <= bank_next;
            case (state)
                IDLE: begin
                    for (int r = 0; r < NUM_REGS; r++)
                        if (hit[r])
                            mem[bank][r] <= hval[r];
                    if (clr_req) begin
                        clr_bank <= bank;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    // clr_req is deliberately not looked at here: no restart or extension.
                    mem[clr_bank][cnt] <= '0;
                    wr_drop            <= we | pair_we;
                    cnt                <= cnt + 1'b1;
                    if (cnt == AW'(NUM_REGS - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_banked_register_file.sv
// Directed plus random bench for banked_register_file against an array-based reference model.
`timescale 1ns/1ps
module tb_banked_register_file;

    localparam int DW = 4;
    localparam int NR = 16;
    localparam int NB = 2;
    localparam int BP = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    waddr = '0;
    logic [3:0]    wdata = '0;
    logic          pair_we = 1'b0;
    logic [2:0]    pair_idx = '0;
    logic [7:0]    pair_din = '0;
    logic [3:0]    raddr = '0;
    logic [3:0]    rdata;
    logic [2:0]    rpair_idx = '0;
    logic [7:0]    rpair_dout;
    logic          bank_we = 1'b0;
    logic [0:0]    bank_in = '0;
    logic [0:0]    bank;
    logic          clr_req = 1'b0;
    logic          busy;
    logic          wr_drop;

    banked_register_file #(.DATA_W(DW), .NUM_REGS(NR), .NUM_BANKS(NB), .BYPASS(BP)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .pair_we(pair_we), .pair_idx(pair_idx), .pair_din(pair_din),
        .raddr(raddr), .rdata(rdata), .rpair_idx(rpair_idx), .rpair_dout(rpair_dout),
        .bank_we(bank_we), .bank_in(bank_in), .bank(bank),
        .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: plain arrays plus clear progress bookkeeping.
    int unsigned mreg [NB][NR];
    int unsigned mbank;
    bit          mclr;
    int unsigned mcb;
    int unsigned mpos;
    bit          mdrop;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_rd(input int idx);
        int unsigned v;
        v = mreg[mbank][idx];
        if (BP != 0 && !mclr) begin
            if (we && int'(waddr) == idx) v = wdata;
            if (pair_we && int'(pair_idx) == idx / 2)
                v = (idx % 2 == 0) ? int'(pair_din[7:4]) : int'(pair_din[3:0]);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < NR; r++)
                mreg[b][r] = 0;
        mbank = 0; mclr = 0; mcb = 0; mpos = 0; mdrop = 0;
    endtask

    task automatic model_edge();
        if (!mclr) begin
            if (we) mreg[mbank][waddr] = wdata;
            if (pair_we) begin
                mreg[mbank][2*pair_idx]   = pair_din[7:4];
                mreg[mbank][2*pair_idx+1] = pair_din[3:0];
            end
            mdrop = 0;
            if (clr_req) begin
                mclr = 1; mcb = mbank; mpos = 0;
            end
        end else begin
            mreg[mcb][mpos] = 0;
            mpos++;
            mdrop = we || pair_we;
            if (mpos == NR) mclr = 0;
        end
        if (bank_we) mbank = bank_in % NB;
    endtask

    // One clock: check combinational reads mid-cycle, advance model at the edge, check registered outputs.
    task automatic step();
        int ev;
        @(negedge clk);
        ev = 2 * int'(rpair_idx);
        chk("rdata", 32'(rdata), exp_rd(int'(raddr)));
        chk("rpair_dout", 32'(rpair_dout), (exp_rd(ev) << 4) | exp_rd(ev + 1));
        @(posedge clk);
        model_edge();
        #1;
        chk("bank", 32'(bank), mbank);
        chk("busy", 32'(busy), 32'(mclr));
        chk("wr_drop", 32'(wr_drop), 32'(mdrop));
    endtask

    task automatic idle_in();
        we = 0; pair_we = 0; bank_we = 0; clr_req = 0;
    endtask

    task automatic wr(input int a, input int d);
        we = 1; waddr = 4'(a); wdata = 4'(d); raddr = 4'(a);
        step();
        we = 0;
    endtask

    task automatic sel(input int b);
        bank_we = 1; bank_in = 1'(b);
        step();
        bank_we = 0;
    endtask

    task automatic rd_all();
        for (int i = 0; i < NR; i++) begin
            raddr = 4'(i); rpair_idx = 3'(i / 2);
            step();
        end
    endtask

    initial begin
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bank", 32'(bank), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_wr_drop", 32'(wr_drop), 0);
        rst = 0;
        rd_all();

        // Single write with same-cycle bypass, then stored read.
        we = 1; waddr = 5; wdata = 4'hA; raddr = 5;
        step();
        chk("bypass_5", 32'(rdata), 32'hA);
        we = 0;
        step();
        chk("stored_5", 32'(rdata), 32'hA);

        // Pair write collides with single write on reg 6: pair data wins.
        pair_we = 1; pair_idx = 3; pair_din = 8'h5C;
        we = 1; waddr = 6; wdata = 4'hF; raddr = 6; rpair_idx = 3;
        step();
        idle_in();
        step();
        chk("pair_reg6", 32'(rdata), 32'h5);
        chk("pair_read3", 32'(rpair_dout), 32'h5C);
        raddr = 7;
        step();

        // Bank isolation.
        wr(2, 3);
        sel(1);
        wr(2, 9);
        raddr = 2;
        step();
        chk("bank1_reg2", 32'(rdata), 32'h9);
        sel(0);
        raddr = 2;
        step();
        chk("bank0_reg2", 32'(rdata), 32'h3);

        // Fill and clear bank 1 while bank 0 holds a pattern; writes during clear are dropped.
        sel(1);
        for (int i = 0; i < NR; i++) wr(i, 4'hF);
        sel(0);
        for (int i = 0; i < NR; i++) wr(i, 4'h7);
        sel(1);
        clr_req = 1;
        step();
        clr_req = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            we = (i % 3 == 0); waddr = 4'(i); wdata = 4'h3; raddr = 4'(i);
            step();
            if (busy) busy_cnt++;
        end
        idle_in();
        chk("busy_len_clear", 32'(busy_cnt), 32'(NR));
        rd_all();
        sel(0);
        rd_all();

        // Clear request repeated mid-clear and bank switch mid-clear.
        sel(1);
        for (int i = 0; i < NR; i++) wr(i, int'($urandom_range(1, 15)));
        clr_req = 1;
        step();
        clr_req = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i < 20; i++) begin
            clr_req = (i == 3);
            bank_we = (i == 5); bank_in = 0;
            step();
            if (busy) busy_cnt++;
        end
        idle_in();
        chk("busy_len_reclr", 32'(busy_cnt), 32'(NR));
        sel(1);
        rd_all();

        // Reset mid-clear aborts and zeroes everything.
        for (int i = 0; i < NR; i++) wr(i, 4'hB);
        sel(0);
        for (int i = 0; i < NR; i++) wr(i, 4'hD);
        sel(1);
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (7) step();
        #2;
        rst = 1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_bank", 32'(bank), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        rd_all();
        sel(1);
        rd_all();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            we        = 1'($urandom_range(0, 1));
            waddr     = 4'($urandom);
            wdata     = 4'($urandom);
            pair_we   = ($urandom_range(0, 3) == 0);
            pair_idx  = 3'($urandom);
            pair_din  = 8'($urandom);
            raddr     = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            rpair_idx = ($urandom_range(0, 3) == 0) ? pair_idx : 3'($urandom);
            bank_we   = ($urandom_range(0, 7) == 0);
            bank_in   = 1'($urandom);
            clr_req   = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_in();
        sel(0);
        rd_all();
        sel(1);
        rd_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
